// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
//   Shared constants and helpers for the multiplexed 7-segment scanner.
//   - Segment encoding is active-low, bit0 = segment a ... bit6 = segment g.
//   - Digit slot numbering: 0 = seconds units (rightmost) .. 5 = hours tens.
//   - Optional build macro SEG_SEP_BLINK_EN (used in seg_display_scanner).
// -----------------------------------------------------------------------------
package seg_pkg;

    localparam int NUM_DIGITS = 6;

    // All segments off (active-low).
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Slot indices, rightmost digit first.
    localparam logic [2:0] IDX_SEC_U  = 3'd0;
    localparam logic [2:0] IDX_SEC_T  = 3'd1;
    localparam logic [2:0] IDX_MIN_U  = 3'd2;
    localparam logic [2:0] IDX_MIN_T  = 3'd3;
    localparam logic [2:0] IDX_HOUR_U = 3'd4;
    localparam logic [2:0] IDX_HOUR_T = 3'd5;

    // Active-low glyphs for BCD 0..9.
    localparam logic [6:0] GLYPH_TABLE [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    typedef logic [3:0]                  bcd_t;
    typedef bcd_t [NUM_DIGITS-1:0]       digits_t;

    // Active-low digit enable with exactly one digit selected.
    function automatic logic [NUM_DIGITS-1:0] digit_enable(input logic [2:0] idx);
        return ~(6'b000001 << idx);
    endfunction

    // The two slots whose decimal point acts as the HH.MM.SS separator.
    function automatic logic is_separator(input logic [2:0] idx);
        return (idx == IDX_MIN_U) || (idx == IDX_HOUR_U);
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// -----------------------------------------------------------------------------
// bcd_to_seg
//   Combinational BCD digit to active-low 7-segment glyph. Codes 10..15 are
//   not valid BCD and render as a blank digit.
// Ports:
//   bcd_i  in   4  BCD digit
//   seg_o  out  7  active-low segments, bit0 = a
// -----------------------------------------------------------------------------
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (bcd_i <= 4'd9) begin
            seg_o = GLYPH_TABLE[bcd_i];
        end
    end

endmodule

// File: rtl/seg_display_scanner.sv
// -----------------------------------------------------------------------------
// seg_display_scanner
//   Drives a 6-digit common-anode multiplexed 7-segment display from the BCD
//   time digits of a digital clock. One digit is lit per scan slot; the time
//   is snapshotted once per frame (six slots) so a frame never mixes seconds.
//
// Parameters:
//   CLK_FREQ  clk frequency in Hz
//   SCAN_HZ   slot rate in Hz; DIV = CLK_FREQ/SCAN_HZ clocks per slot (>= 2)
//
// Ports:
//   clk          in   1  system clock
//   rst_n        in   1  synchronous reset, active-low
//   sec_units    in   4  BCD digit 0 (rightmost)
//   sec_tens     in   4  BCD digit 1
//   min_units    in   4  BCD digit 2
//   min_tens     in   4  BCD digit 3
//   hour_units   in   4  BCD digit 4
//   hour_tens    in   4  BCD digit 5 (leftmost)
//   is_am        in   1  1 = AM, 0 = PM
//   seg          out  7  active-low segments, bit0 = a
//   dp           out  1  active-low decimal point
//   an           out  6  active-low digit enables, an[i] = digit i
//
// Build option:
//   SEG_SEP_BLINK_EN  when defined, the separator points (digits 2 and 4)
//                     blink: a phase flop toggles on each snapshot whose
//                     seconds-units digit differs from the previous one, and
//                     separators are lit only while the phase is 0.
//
// Handshake: none. Inputs are sampled freely; outputs are all registered.
// -----------------------------------------------------------------------------
module seg_display_scanner
    import seg_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned SCAN_HZ  = 1000
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sec_units,
    input  logic [3:0] sec_tens,
    input  logic [3:0] min_units,
    input  logic [3:0] min_tens,
    input  logic [3:0] hour_units,
    input  logic [3:0] hour_tens,
    input  logic       is_am,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an
);

    localparam int unsigned DIV = CLK_FREQ / SCAN_HZ;
    localparam int          PW  = (DIV > 1) ? $clog2(DIV) : 1;

    if (DIV < 2) begin : g_div_check
        $error("seg_display_scanner: CLK_FREQ/SCAN_HZ must be at least 2");
    end

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [PW-1:0]          presc_q, presc_d;
    logic [2:0]             idx_q, idx_d;
    digits_t                shadow_q, shadow_d;
    logic                   am_q, am_d;
    logic [6:0]             seg_q, seg_d;
    logic                   dp_q, dp_d;
    logic [NUM_DIGITS-1:0]  an_q, an_d;
`ifdef SEG_SEP_BLINK_EN
    logic                   phase_q, phase_d;
`endif

    logic       tick;
    logic       wrap;
    logic       sep_dp;
    bcd_t       cur_bcd;
    logic [6:0] cur_glyph;

    // ---------------------------------------------------------------------
    // Slot timing and snapshot
    // ---------------------------------------------------------------------
    always_comb begin
        tick = (presc_q == PW'(DIV - 1));
        wrap = tick && (idx_q == IDX_HOUR_T);

        presc_d = tick ? '0 : presc_q + PW'(1);

        idx_d = idx_q;
        if (tick) begin
            idx_d = wrap ? IDX_SEC_U : idx_q + 3'd1;
        end

        shadow_d = shadow_q;
        am_d     = am_q;
        if (wrap) begin
            shadow_d[IDX_SEC_U]  = sec_units;
            shadow_d[IDX_SEC_T]  = sec_tens;
            shadow_d[IDX_MIN_U]  = min_units;
            shadow_d[IDX_MIN_T]  = min_tens;
            shadow_d[IDX_HOUR_U] = hour_units;
            shadow_d[IDX_HOUR_T] = hour_tens;
            am_d                 = is_am;
        end
    end

`ifdef SEG_SEP_BLINK_EN
    // Toggle only when the snapshot actually carries a new second, so the
    // blink rate follows the clock and not the scan rate.
    always_comb begin
        phase_d = phase_q;
        if (wrap && (sec_units != shadow_q[IDX_SEC_U])) begin
            phase_d = ~phase_q;
        end
        sep_dp = phase_d;
    end
`else
    assign sep_dp = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // Output decode. seg/dp are computed from the next-state index and
    // shadow so that, on a tick, they already hold the new digit during the
    // blanked cycle and the digit lights cleanly one cycle later.
    // ---------------------------------------------------------------------
    assign cur_bcd = shadow_d[idx_d];

    bcd_to_seg u_bcd_to_seg (
        .bcd_i (cur_bcd),
        .seg_o (cur_glyph)
    );

    always_comb begin
        // Leading-zero suppression on the hours tens digit.
        if ((idx_d == IDX_HOUR_T) && (shadow_d[IDX_HOUR_T] == 4'd0)) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = cur_glyph;
        end

        if (idx_d == IDX_SEC_U) begin
            dp_d = am_d;             // PM indicator: lit when is_am == 0
        end else if (is_separator(idx_d)) begin
            dp_d = sep_dp;
        end else begin
            dp_d = 1'b1;
        end

        // One blank cycle after every tick avoids ghosting while the
        // segment lines settle on the next digit's pattern.
        an_d = tick ? {NUM_DIGITS{1'b1}} : digit_enable(idx_q);
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q  <= '0;
            idx_q    <= IDX_SEC_U;
            shadow_q <= '0;
            am_q     <= 1'b1;
            seg_q    <= SEG_BLANK;
            dp_q     <= 1'b1;
            an_q     <= {NUM_DIGITS{1'b1}};
`ifdef SEG_SEP_BLINK_EN
            phase_q  <= 1'b0;
`endif
        end else begin
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            am_q     <= am_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            an_q     <= an_d;
`ifdef SEG_SEP_BLINK_EN
            phase_q  <= phase_d;
`endif
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// -----------------------------------------------------------------------------
// tb_seg_display_scanner
//   Self-checking bench for seg_display_scanner with CLK_FREQ=100, SCAN_HZ=10
//   (10 clocks per slot, 60 clocks per frame). A cycle-count reference model
//   pushes the expected {an, seg, dp} after every edge; the value is popped
//   and compared once the DUT outputs have settled. Directed checks cover the
//   reset values, the 12:34:56 frame, snapshot hold-off, leading-zero and
//   invalid-code blanking, and the separator behaviour.
// -----------------------------------------------------------------------------
module tb_seg_display_scanner;

    localparam int CLK_FREQ = 100;
    localparam int SCAN_HZ  = 10;
    localparam int DIV      = CLK_FREQ / SCAN_HZ;
    localparam int FRAME    = 6 * DIV;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] su = 4'd0, st = 4'd0, mu = 4'd0, mt = 4'd0, hu = 4'd0, ht = 4'd0;
    logic       is_am = 1'b1;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;

    always #5 clk = ~clk;

    seg_display_scanner #(
        .CLK_FREQ (CLK_FREQ),
        .SCAN_HZ  (SCAN_HZ)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sec_units  (su),
        .sec_tens   (st),
        .min_units  (mu),
        .min_tens   (mt),
        .hour_units (hu),
        .hour_tens  (ht),
        .is_am      (is_am),
        .seg        (seg),
        .dp         (dp),
        .an         (an)
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    int          checks = 0;
    int          errors = 0;
    logic [13:0] exp_q[$];

    // Reference model: k counts clocks since the last reset edge.
    int          k = 0;
    logic [3:0]  m_dig [6];
    logic        m_am = 1'b1;
    logic        m_phase = 1'b0;

    logic [5:0]  an_tbl  [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
    logic [6:0]  seg_tbl [6] = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
`ifdef SEG_SEP_BLINK_EN
    logic        sep_tbl [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic        sep_frame2 = 1'b1;   // 0 -> 6 at the first snapshot toggles the phase
`else
    logic        sep_tbl [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic        sep_frame2 = 1'b0;
`endif

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (k=%0d)", tag, act, exp, k);
        end
    endtask

    function automatic logic [6:0] ref_glyph(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Expected {an, seg, dp} for the cycle numbered k.
    function automatic logic [13:0] ref_outputs();
        int         slot_pos;
        int         slot_idx;
        logic [5:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        if (k == 0) return {6'h3F, 7'h7F, 1'b1};
        slot_pos = k % DIV;
        slot_idx = (k / DIV) % 6;
        e_an  = (slot_pos == 0) ? 6'h3F : ~(6'b000001 << slot_idx);
        e_seg = (slot_idx == 5 && m_dig[5] == 4'd0) ? 7'h7F : ref_glyph(m_dig[slot_idx]);
        if (slot_idx == 0)
            e_dp = m_am;
        else if (slot_idx == 2 || slot_idx == 4)
`ifdef SEG_SEP_BLINK_EN
            e_dp = m_phase;
`else
            e_dp = 1'b0;
`endif
        else
            e_dp = 1'b1;
        return {e_an, e_seg, e_dp};
    endfunction

    // Advance the model across one clock edge using the inputs the DUT sees.
    task automatic model_edge();
        if (!rst_n) begin
            k = 0;
            m_dig = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
            m_am = 1'b1;
            m_phase = 1'b0;
        end else begin
            if (k % FRAME == FRAME - 1) begin
                if (su != m_dig[0]) m_phase = ~m_phase;
                m_dig = '{su, st, mu, mt, hu, ht};
                m_am = is_am;
            end
            k++;
        end
        exp_q.push_back(ref_outputs());
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic step();
        logic [13:0] e;
        @(posedge clk);
        model_edge();
        #1;
        e = exp_q.pop_front();
        check_eq("slot_outputs", 32'({an, seg, dp}), 32'(e));
        check_eq("an_one_hot", 32'($countones(~an) <= 1), 32'(1));
    endtask

    task automatic run_to(input int target);
        for (int n = 0; n < 2000 && k < target; n++) step();
        if (k != target) check_eq("run_to_bound", 32'(k), 32'(target));
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        m_dig = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};

        // Power-on reset.
        rst_n = 1'b0;
        repeat (3) step();
        check_eq("reset_an",  32'(an),  32'(6'h3F));
        check_eq("reset_seg", 32'(seg), 32'(7'h7F));
        check_eq("reset_dp",  32'(dp),  32'(1'b1));
        rst_n = 1'b1;

        // 12:34:56 PM, visible from the second frame.
        ht = 4'd1; hu = 4'd2; mt = 4'd3; mu = 4'd4; st = 4'd5; su = 4'd6;
        is_am = 1'b0;
        run_to(1);
        check_eq("frame0_zero_glyph", 32'(seg), 32'(7'h40));
        for (int i = 0; i < 6; i++) begin
            run_to(FRAME + DIV * i);
            check_eq("frame2_blank_slot", 32'(an), 32'(6'h3F));
            run_to(FRAME + DIV * i + 1);
            check_eq("frame2_an",  32'(an),  32'(an_tbl[i]));
            check_eq("frame2_seg", 32'(seg), 32'(seg_tbl[i]));
            if (i == 0)
                check_eq("frame2_pm_dp", 32'(dp), 32'(1'b0));
            else if (i == 2 || i == 4)
                check_eq("frame2_sep_dp", 32'(dp), 32'(sep_frame2));
            else
                check_eq("frame2_dp_off", 32'(dp), 32'(1'b1));
        end

        // Mid-frame input changes wait for the next snapshot.
        run_to(2 * FRAME + 3 * DIV + 5);
        su = 4'd7;
        hu = 4'd9;
        run_to(2 * FRAME + 4 * DIV + 1);
        check_eq("snap_hour_units_held", 32'(seg), 32'(7'h24));
        run_to(3 * FRAME + 1);
        check_eq("snap_sec_units_new", 32'(seg), 32'(7'h78));

        // Leading zero and invalid BCD, captured at the start of frame 5.
        run_to(3 * FRAME + 5);
        ht = 4'd0;
        mt = 4'hC;
        run_to(3 * FRAME + 4 * DIV + 1);
        check_eq("snap_hour_units_new", 32'(seg), 32'(7'h10));
        run_to(3 * FRAME + 5 * DIV + 1);
        check_eq("hour_tens_one", 32'(seg), 32'(7'h79));
        run_to(4 * FRAME + 3 * DIV + 1);
        check_eq("invalid_code_blank", 32'(seg), 32'(7'h7F));
        run_to(4 * FRAME + 5 * DIV + 1);
        check_eq("leading_zero_an",  32'(an),  32'(6'h1F));
        check_eq("leading_zero_seg", 32'(seg), 32'(7'h7F));

        // Mid-frame reset for a single edge.
        run_to(5 * FRAME + 3 * DIV + 3);
        rst_n = 1'b0;
        step();
        check_eq("midframe_reset_an",  32'(an),  32'(6'h3F));
        check_eq("midframe_reset_seg", 32'(seg), 32'(7'h7F));
        check_eq("midframe_reset_dp",  32'(dp),  32'(1'b1));
        rst_n = 1'b1;
        su = 4'd0; st = 4'd5; mu = 4'd4; mt = 4'd3; hu = 4'd2; ht = 4'd1;
        is_am = 1'b1;
        run_to(1);
        check_eq("first_slot_an", 32'(an), 32'(6'h3E));

        // Seconds units 0 -> 1 -> 1 -> 2 across successive snapshots.
        run_to(FRAME + 1);
        check_eq("am_dp_off", 32'(dp), 32'(1'b1));
        run_to(FRAME + 2 * DIV + 1);
        check_eq("sep_frame_a", 32'(dp), 32'(sep_tbl[0]));
        su = 4'd1;
        run_to(2 * FRAME + 2 * DIV + 1);
        check_eq("sep_frame_b", 32'(dp), 32'(sep_tbl[1]));
        run_to(3 * FRAME + 2 * DIV + 1);
        check_eq("sep_frame_c", 32'(dp), 32'(sep_tbl[2]));
        su = 4'd2;
        is_am = 1'b0;
        run_to(4 * FRAME + 2 * DIV + 1);
        check_eq("sep_frame_d", 32'(dp), 32'(sep_tbl[3]));
        run_to(5 * FRAME + 1);
        check_eq("pm_dp_on", 32'(dp), 32'(1'b0));

        // A few random digits through the model-checked scan.
        for (int f = 0; f < 3; f++) begin
            su = 4'($urandom_range(0, 15)); st = 4'($urandom_range(0, 5));
            mu = 4'($urandom_range(0, 9));  mt = 4'($urandom_range(0, 5));
            hu = 4'($urandom_range(0, 9));  ht = 4'($urandom_range(0, 1));
            is_am = 1'($urandom_range(0, 1));
            run_to(k + FRAME);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
